dly_load_sequencer: RTL and testbench
=====================================

Name: dly_load_sequencer

Overview:
- Command-driven controller that sits directly upstream of a bank of pipelined fine output-delay elements.
- Accepts (lane, 8-bit delay) write commands over a valid/ready handshake.
- Drives a shared delay bus and a per-lane one-cycle load strobe.
- On an apply command, waits a programmable gap, then issues one common set strobe so all lanes switch delay on the same clock edge.

Parameters:
- NUM_LANES, 10: number of delay elements driven (1..16).
- ADDR_WIDTH, 4: width of cmd_addr; 2**ADDR_WIDTH >= NUM_LANES.
- SET_GAP, 2: idle cycles between apply-command acceptance and the dly_set pulse (0..15).
- FINE_MAX, 4: largest legal fine value, delay[2:0].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_apply  input  1  1 = apply (set) command; 0 = lane load command.
- cmd_addr  input  ADDR_WIDTH  target lane (load commands only).
- cmd_delay  input  8  [7:3] coarse tap, [2:0] fine step (load commands only).
- err_clr  input  1  clears sticky error flags.
- dly_data  output  8  shared delay bus to all lanes.
- dly_ld  output  NUM_LANES  one-hot one-cycle load strobe, one bit per lane.
- dly_set  output  1  common one-cycle set strobe.
- pending  output  1  at least one lane loaded since the last set.
- err_fine  output  1  sticky: a fine value > FINE_MAX was clamped.
- err_addr  output  1  sticky: a load command targeted cmd_addr >= NUM_LANES.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - dly_data = 0, dly_ld = 0, dly_set = 0, pending = 0, err_fine = 0, err_addr = 0, gap counter = 0.
  - cmd_ready = 1 on the first edge after release.
- All outputs are registered. cmd_ready is decoded from the state register: 1 only in IDLE.
- A command is accepted on a clock edge where cmd_valid & cmd_ready = 1. cmd_* are ignored at all other times.
- States: IDLE, LOAD, WAIT, SET.
- IDLE:
  - Accept with cmd_apply = 0 -> LOAD.
  - Accept with cmd_apply = 1 -> WAIT if SET_GAP > 0, otherwise SET. The gap counter is loaded with SET_GAP.
- LOAD (exactly 1 cycle, then IDLE):
  - dly_data = {cmd_delay[7:3], fine}, where fine = min(cmd_delay[2:0], FINE_MAX).
  - dly_ld[cmd_addr] = 1 if cmd_addr < NUM_LANES.
  - pending is set.
  - If the fine value was clamped, err_fine is set.
  - If cmd_addr >= NUM_LANES: no dly_ld bit asserts, err_addr is set, pending is unchanged, and dly_data still updates.
- Load latency: a command accepted at edge k gives dly_ld high for the cycle after edge k+1. Peak throughput is one load per 2 cycles.
- dly_data holds its last value outside LOAD. It is never changed in WAIT or SET, so a lane samples stable data.
- WAIT:
  - The gap counter decrements each cycle.
  - Transition to SET when the counter reaches 1.
  - Total WAIT dwell = SET_GAP cycles.
- SET (exactly 1 cycle, then IDLE):
  - dly_set = 1 and pending is cleared.
  - An apply command is always executed, even when pending = 0. This re-applies the same values and is harmless.
- Apply latency: a command accepted at edge k gives dly_set high for the cycle after edge k+1+SET_GAP.
- dly_ld and dly_set are never high in the same cycle. At most one dly_ld bit is high in any cycle.
- err_clr:
  - Clears both sticky flags on the next edge.
  - If the same edge also sets a flag, the set wins.
- Reset mid-operation (LOAD, WAIT or SET) aborts immediately: strobes drop asynchronously and no pending strobe is issued after release.
- cmd_addr comparison is unsigned. Values NUM_LANES..2**ADDR_WIDTH-1 are out of range.

Test Plan:
- Reset, then load addr=3, delay=8'h2B (fine 3) -> dly_ld = 10'b0000001000 for one cycle two edges after acceptance, dly_data = 8'h2B, pending = 1, err_fine = 0; cmd_ready low exactly one cycle.
- Load addr=0, delay=8'h17 (fine 7) -> dly_data = 8'h14, dly_ld[0] pulse, err_fine = 1 and held; pulse err_clr -> err_fine = 0.
- Load addr=12 (NUM_LANES=10) -> no dly_ld bit asserts, err_addr = 1, pending unchanged, command consumed (cmd_ready back to 1 after one cycle).
- Load two lanes, then apply with SET_GAP=2, accepted at edge k -> dly_set high for exactly one cycle after edge k+3, pending = 0 after it, cmd_ready low for 3 cycles; repeat with SET_GAP=0 -> dly_set after edge k+1.
- Back-to-back cmd_valid held high with 4 loads plus 1 apply -> one load accepted every 2 cycles, dly_ld/dly_set never overlap, data stable during WAIT/SET.
- Assert rst_n low during WAIT -> all outputs 0 immediately, no dly_set after release, pending = 0, cmd_ready = 1.

Source files
------------

// File: rtl/dly_load_sequencer_if.sv
// Command and delay-bus bundle between a delay-load master and dly_load_sequencer.
interface dly_load_sequencer_if #(
   parameter int unsigned NUM_LANES  = 10,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_apply;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [7:0]            cmd_delay;
   logic                  err_clr;
   logic [7:0]            dly_data;
   logic [NUM_LANES-1:0]  dly_ld;
   logic                  dly_set;
   logic                  pending;
   logic                  err_fine;
   logic                  err_addr;

   modport master (
      output cmd_valid, cmd_apply, cmd_addr, cmd_delay, err_clr,
      input  cmd_ready, dly_data, dly_ld, dly_set, pending, err_fine, err_addr
   );

   modport slave (
      input  cmd_valid, cmd_apply, cmd_addr, cmd_delay, err_clr,
      output cmd_ready, dly_data, dly_ld, dly_set, pending, err_fine, err_addr
   );
endinterface

// File: rtl/dly_load_sequencer.sv
// Loads per-lane fine-delay values over a shared bus and issues a common,
// gap-delayed set strobe so every lane switches on the same edge.
module dly_load_sequencer #(
   parameter int unsigned NUM_LANES  = 10,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned SET_GAP    = 2,
   parameter int unsigned FINE_MAX   = 4
) (
   input logic clk,
   input logic rst_n,
   dly_load_sequencer_if.slave bus
);
   localparam int unsigned DATA_W = 8;
   localparam int unsigned FINE_W = 3;
   localparam int unsigned GAP_W  = 4;
   localparam logic [FINE_W-1:0] FINE_LIM = FINE_W'(FINE_MAX);
   localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(SET_GAP);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, SET} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_W-1:0]     delay;
   } load_cmd_t;

   state_t               state, state_nxt;
   logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
   load_cmd_t            cmd_q, cmd_q_nxt;
   logic                 accept;
   logic                 fine_clamp;
   logic                 in_range;

   logic [DATA_W-1:0]    dly_data_q, dly_data_nxt;
   logic [NUM_LANES-1:0] dly_ld_q, dly_ld_nxt;
   logic                 dly_set_q, dly_set_nxt;
   logic                 pending_q, pending_nxt;
   logic                 err_fine_q, err_fine_nxt;
   logic                 err_addr_q, err_addr_nxt;
   logic                 ready_q, ready_nxt;

   assign accept     = bus.cmd_valid & ready_q;
   assign fine_clamp = cmd_q.delay[FINE_W-1:0] > FINE_LIM;
   assign in_range   = 32'(cmd_q.addr) < NUM_LANES;

   // State register, gap counter and captured load command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gap_cnt <= '0;
         cmd_q   <= '0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_cnt_nxt;
         cmd_q   <= cmd_q_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      cmd_q_nxt   = cmd_q;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.cmd_apply) begin
                  gap_cnt_nxt = GAP_INIT;
                  state_nxt   = (SET_GAP > 0) ? WAIT : SET;
               end else begin
                  cmd_q_nxt.addr  = bus.cmd_addr;
                  cmd_q_nxt.delay = bus.cmd_delay;
                  state_nxt       = LOAD;
               end
            end
         end
         LOAD: state_nxt = IDLE;
         WAIT: begin
            gap_cnt_nxt = gap_cnt - GAP_W'(1);
            if (gap_cnt <= GAP_W'(1)) state_nxt = SET;
         end
         SET:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      dly_data_nxt = dly_data_q;
      dly_ld_nxt   = '0;
      dly_set_nxt  = 1'b0;
      pending_nxt  = pending_q;
      err_fine_nxt = err_fine_q & ~bus.err_clr;
      err_addr_nxt = err_addr_q & ~bus.err_clr;
      ready_nxt    = (state_nxt == IDLE);
      case (state)
         LOAD: begin
            dly_data_nxt = {cmd_q.delay[DATA_W-1:FINE_W],
                            fine_clamp ? FINE_LIM : cmd_q.delay[FINE_W-1:0]};
            if (fine_clamp) err_fine_nxt = 1'b1;
            if (in_range) begin
               dly_ld_nxt  = NUM_LANES'(1) << cmd_q.addr;
               pending_nxt = 1'b1;
            end else begin
               err_addr_nxt = 1'b1;
            end
         end
         SET: begin
            dly_set_nxt = 1'b1;
            pending_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   // Output registers; reset drops the strobes immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_data_q <= '0;
         dly_ld_q   <= '0;
         dly_set_q  <= 1'b0;
         pending_q  <= 1'b0;
         err_fine_q <= 1'b0;
         err_addr_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         dly_data_q <= dly_data_nxt;
         dly_ld_q   <= dly_ld_nxt;
         dly_set_q  <= dly_set_nxt;
         pending_q  <= pending_nxt;
         err_fine_q <= err_fine_nxt;
         err_addr_q <= err_addr_nxt;
         ready_q    <= ready_nxt;
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.dly_data  = dly_data_q;
   assign bus.dly_ld    = dly_ld_q;
   assign bus.dly_set   = dly_set_q;
   assign bus.pending   = pending_q;
   assign bus.err_fine  = err_fine_q;
   assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_dly_load_sequencer.sv
// Directed bench for dly_load_sequencer: SET_GAP=2 main instance, SET_GAP=0 second instance.
module tb_dly_load_sequencer;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   dly_load_sequencer_if #(.NUM_LANES(10), .ADDR_WIDTH(4)) bus ();
   dly_load_sequencer_if #(.NUM_LANES(10), .ADDR_WIDTH(4)) bus0 ();

   dly_load_sequencer #(.NUM_LANES(10), .ADDR_WIDTH(4), .SET_GAP(2), .FINE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   dly_load_sequencer #(.NUM_LANES(10), .ADDR_WIDTH(4), .SET_GAP(0), .FINE_MAX(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for ready, presents one command, returns in the cycle after acceptance
   task automatic send(input logic apply, input logic [3:0] addr, input logic [7:0] delay);
      int w = 0;
      while (bus.cmd_ready !== 1'b1 && w < 20) begin tick(); w++; end
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL send_ready_timeout: got %b want 1", bus.cmd_ready); end
      bus.cmd_valid = 1'b1; bus.cmd_apply = apply; bus.cmd_addr = addr; bus.cmd_delay = delay;
      tick();
      bus.cmd_valid = 1'b0; bus.cmd_apply = 1'b0; bus.cmd_addr = 4'hF; bus.cmd_delay = 8'hFF;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++; if (bus.dly_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", bus.dly_data); end
      n_cmp++; if (bus.dly_ld !== 10'h000) begin n_err++; $display("FAIL rst_ld: got %h want 000", bus.dly_ld); end
      n_cmp++; if ({bus.dly_set, bus.pending, bus.err_fine, bus.err_addr} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {bus.dly_set, bus.pending, bus.err_fine, bus.err_addr}); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready); end
      n_cmp++; if (bus0.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready0: got %b want 1", bus0.cmd_ready); end
   endtask

   task automatic test_load();
      send(1'b0, 4'd3, 8'h2B);
      n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL load_busy: got %b want 0", bus.cmd_ready); end
      n_cmp++; if (bus.dly_ld !== 10'h000) begin n_err++; $display("FAIL load_early: got %h want 000", bus.dly_ld); end
      tick();
      n_cmp++; if (bus.dly_ld !== 10'h008) begin n_err++; $display("FAIL load_ld3: got %h want 008", bus.dly_ld); end
      n_cmp++; if (bus.dly_data !== 8'h2B) begin n_err++; $display("FAIL load_data: got %h want 2B", bus.dly_data); end
      n_cmp++; if ({bus.pending, bus.err_fine, bus.cmd_ready} !== 3'b101) begin n_err++; $display("FAIL load_flags: got %b want 101", {bus.pending, bus.err_fine, bus.cmd_ready}); end
      tick();
      n_cmp++; if (bus.dly_ld !== 10'h000) begin n_err++; $display("FAIL load_onecycle: got %h want 000", bus.dly_ld); end
   endtask

   task automatic test_fine_clamp();
      send(1'b0, 4'd0, 8'h17);
      tick();
      n_cmp++; if (bus.dly_data !== 8'h14) begin n_err++; $display("FAIL clamp_data: got %h want 14", bus.dly_data); end
      n_cmp++; if (bus.dly_ld !== 10'h001) begin n_err++; $display("FAIL clamp_ld0: got %h want 001", bus.dly_ld); end
      n_cmp++; if (bus.err_fine !== 1'b1) begin n_err++; $display("FAIL clamp_err: got %b want 1", bus.err_fine); end
      repeat (3) tick();
      n_cmp++; if (bus.err_fine !== 1'b1) begin n_err++; $display("FAIL clamp_sticky: got %b want 1", bus.err_fine); end
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      n_cmp++; if (bus.err_fine !== 1'b0) begin n_err++; $display("FAIL clamp_clr: got %b want 0", bus.err_fine); end
   endtask

   task automatic test_addr_err();
      send(1'b0, 4'd12, 8'h52);
      n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL addr_busy: got %b want 0", bus.cmd_ready); end
      tick();
      n_cmp++; if (bus.dly_ld !== 10'h000) begin n_err++; $display("FAIL addr_no_ld: got %h want 000", bus.dly_ld); end
      n_cmp++; if ({bus.err_addr, bus.pending, bus.err_fine, bus.cmd_ready} !== 4'b1101) begin n_err++; $display("FAIL addr_flags: got %b want 1101", {bus.err_addr, bus.pending, bus.err_fine, bus.cmd_ready}); end
      n_cmp++; if (bus.dly_data !== 8'h52) begin n_err++; $display("FAIL addr_data: got %h want 52", bus.dly_data); end
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      n_cmp++; if (bus.err_addr !== 1'b0) begin n_err++; $display("FAIL addr_clr: got %b want 0", bus.err_addr); end
   endtask

   task automatic test_apply();
      send(1'b0, 4'd1, 8'h3A); tick();
      send(1'b0, 4'd2, 8'h44); tick();
      n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL apply_pend_pre: got %b want 1", bus.pending); end
      send(1'b1, 4'd0, 8'h00);
      for (int c = 1; c <= 3; c++) begin
         n_cmp++; if ({bus.cmd_ready, bus.dly_set, bus.pending} !== 3'b001) begin n_err++; $display("FAIL apply_wait c%0d: got %b want 001", c, {bus.cmd_ready, bus.dly_set, bus.pending}); end
         n_cmp++; if (bus.dly_data !== 8'h44) begin n_err++; $display("FAIL apply_data c%0d: got %h want 44", c, bus.dly_data); end
         tick();
      end
      n_cmp++; if ({bus.cmd_ready, bus.dly_set, bus.pending} !== 3'b110) begin n_err++; $display("FAIL apply_set: got %b want 110", {bus.cmd_ready, bus.dly_set, bus.pending}); end
      tick();
      n_cmp++; if (bus.dly_set !== 1'b0) begin n_err++; $display("FAIL apply_onecycle: got %b want 0", bus.dly_set); end
   endtask

   task automatic test_apply_gap0();
      bus0.cmd_valid = 1'b1; bus0.cmd_apply = 1'b0; bus0.cmd_addr = 4'd5; bus0.cmd_delay = 8'h21;
      tick();
      bus0.cmd_valid = 1'b0;
      tick();
      n_cmp++; if ({bus0.dly_ld, bus0.pending} !== {10'h020, 1'b1}) begin n_err++; $display("FAIL gap0_load: got %h/%b want 020/1", bus0.dly_ld, bus0.pending); end
      bus0.cmd_valid = 1'b1; bus0.cmd_apply = 1'b1;
      tick();
      bus0.cmd_valid = 1'b0; bus0.cmd_apply = 1'b0;
      n_cmp++; if ({bus0.cmd_ready, bus0.dly_set} !== 2'b00) begin n_err++; $display("FAIL gap0_busy: got %b want 00", {bus0.cmd_ready, bus0.dly_set}); end
      tick();
      n_cmp++; if ({bus0.cmd_ready, bus0.dly_set, bus0.pending} !== 3'b110) begin n_err++; $display("FAIL gap0_set: got %b want 110", {bus0.cmd_ready, bus0.dly_set, bus0.pending}); end
      tick();
      n_cmp++; if (bus0.dly_set !== 1'b0) begin n_err++; $display("FAIL gap0_onecycle: got %b want 0", bus0.dly_set); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  lanes  [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
      logic [7:0]  delays [5] = '{8'h08, 8'h11, 8'h1A, 8'h23, 8'h00};
      int          acc_cyc [5];
      int          idx = 0;
      int          ld_cnt = 0;
      int          set_cnt = 0;
      int          set_cyc = -1;
      logic        acc;
      logic [9:0]  seen = '0;
      bus.cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (idx < 5) begin
            bus.cmd_apply = (idx == 4); bus.cmd_addr = lanes[idx]; bus.cmd_delay = delays[idx];
         end else begin
            bus.cmd_valid = 1'b0;
         end
         acc = bus.cmd_valid & bus.cmd_ready;
         n_cmp++; if ((bus.dly_ld != 10'h000) && bus.dly_set) begin n_err++; $display("FAIL b2b_overlap c%0d: got ld=%h set=1 want no overlap", cyc, bus.dly_ld); end
         n_cmp++; if (!$onehot0(bus.dly_ld)) begin n_err++; $display("FAIL b2b_onehot c%0d: got %h want one-hot", cyc, bus.dly_ld); end
         if (idx == 5) begin
            n_cmp++; if (bus.dly_data !== 8'h23) begin n_err++; $display("FAIL b2b_stable c%0d: got %h want 23", cyc, bus.dly_data); end
         end
         if (bus.dly_ld != 10'h000) ld_cnt++;
         seen |= bus.dly_ld;
         if (bus.dly_set) begin set_cnt++; set_cyc = cyc; end
         tick();
         if (acc) begin acc_cyc[idx] = cyc; idx++; end
      end
      bus.cmd_valid = 1'b0;
      n_cmp++; if (idx !== 5) begin n_err++; $display("FAIL b2b_accepted: got %0d want 5", idx); end
      for (int i = 1; i < 5; i++) begin
         n_cmp++; if (acc_cyc[i] - acc_cyc[i-1] !== 2) begin n_err++; $display("FAIL b2b_spacing %0d: got %0d want 2", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
      n_cmp++; if ({ld_cnt, seen} !== {32'd4, 10'h0F0}) begin n_err++; $display("FAIL b2b_loads: got %0d/%h want 4/0f0", ld_cnt, seen); end
      n_cmp++; if (set_cnt !== 1) begin n_err++; $display("FAIL b2b_setcnt: got %0d want 1", set_cnt); end
      n_cmp++; if (set_cyc !== acc_cyc[4] + 4) begin n_err++; $display("FAIL b2b_setcyc: got %0d want %0d", set_cyc, acc_cyc[4] + 4); end
   endtask

   task automatic test_reset_wait();
      send(1'b0, 4'd9, 8'h01); tick();
      n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL rstw_pend_pre: got %b want 1", bus.pending); end
      send(1'b1, 4'd0, 8'h00);
      tick();
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.dly_data, bus.dly_ld} !== 18'h0) begin n_err++; $display("FAIL rstw_bus: got %h/%h want 00/000", bus.dly_data, bus.dly_ld); end
      n_cmp++; if ({bus.dly_set, bus.pending, bus.err_fine, bus.err_addr, bus.cmd_ready} !== 5'b0) begin n_err++; $display("FAIL rstw_flags: got %b want 00000", {bus.dly_set, bus.pending, bus.err_fine, bus.err_addr, bus.cmd_ready}); end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_cmp++; if (bus.dly_set !== 1'b0) begin n_err++; $display("FAIL rstw_noset c%0d: got %b want 0", c, bus.dly_set); end
      end
      n_cmp++; if ({bus.pending, bus.cmd_ready} !== 2'b01) begin n_err++; $display("FAIL rstw_after: got %b want 01", {bus.pending, bus.cmd_ready}); end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      bus.cmd_valid = 1'b0; bus.cmd_apply = 1'b0; bus.cmd_addr = '0; bus.cmd_delay = '0; bus.err_clr = 1'b0;
      bus0.cmd_valid = 1'b0; bus0.cmd_apply = 1'b0; bus0.cmd_addr = '0; bus0.cmd_delay = '0; bus0.err_clr = 1'b0;
      test_reset();
      test_load();
      test_fine_clamp();
      test_addr_err();
      test_apply();
      test_apply_gap0();
      repeat (2) tick();
      test_back_to_back();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
